// File: rtl/game_pkg.sv
// Shared game types: FSM state encoding and the draw marker for the winner bus.
// Imported by game_sequencer, simulate and the turn-aware draw_* blocks.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_READY,
    AIM,
    FLIGHT,
    RESOLVE,
    OVER
  } game_state_t;

  // Wide enough for 8 players; truncating all-ones keeps it all-ones.
  localparam logic [3:0] NO_WINNER = 4'hF;

endpackage

// File: rtl/wind_lfsr.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, advanced on step.
// nxt exposes the stepped value so wind can be latched in the same cycle.
module wind_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  output logic [7:0] q,
  output logic [7:0] nxt
);

  assign nxt = {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};

  always_ff @(posedge clk) begin
    if (rst)       q <= SEED;
    else if (step) q <= nxt;
  end

endmodule

// File: rtl/game_sequencer.sv
// N-player turn/round sequencer: throw gating, survivor rotation,
// HP bookkeeping, aim timeout, per-turn wind and winner detection.
module game_sequencer
  import game_pkg::*;
#(
  parameter int         N_PLAYERS   = 2,
  parameter int         HP_W        = 7,
  parameter int         HP_INIT     = 100,
  parameter int         TURN_W      = 3,
  parameter int         WIND_W      = 3,
  parameter int         AIM_TIMEOUT = 600,
  parameter logic [7:0] LFSR_SEED   = 8'hA5,
  localparam int        PW          = $clog2(N_PLAYERS)
) (
  input  logic                      clk60MHz,
  input  logic                      rst,
  input  logic                      start,
  input  logic [N_PLAYERS-1:0]      ready,
  input  logic                      frame_tick,
  input  logic                      throw_req,
  input  logic                      throw_done,
  input  logic                      hit_valid,
  input  logic [PW-1:0]             hit_player,
  input  logic [HP_W-1:0]           hit_damage,
  output game_state_t               state,
  output logic [PW-1:0]             active_player,
  output logic [TURN_W-1:0]         turn,
  output logic [WIND_W-1:0]         wind,
  output logic                      throw_en,
  output logic [N_PLAYERS*HP_W-1:0] hp,
  output logic                      game_over,
  output logic [PW:0]               winner
);

  localparam int CW = $clog2(AIM_TIMEOUT + 1);
  localparam logic [PW:0] NO_WIN = NO_WINNER[PW:0];
  localparam logic [N_PLAYERS*HP_W-1:0] HP_FULL =
    {N_PLAYERS{HP_W'(HP_INIT)}};

  game_state_t      state_n;
  logic [CW-1:0]    aim_cnt;
  logic             aim_expire;
  logic [N_PLAYERS-1:0] alive;
  logic [PW:0]      alive_cnt;
  logic             advance;
  logic             restart;
  logic             hit_ok;
  logic [HP_W-1:0]  hit_cur;
  logic [7:0]       lfsr_q;
  logic [7:0]       lfsr_nxt;

  function automatic logic [PW:0] count_alive(
    input logic [N_PLAYERS-1:0] a
  );
    logic [PW:0] c;
    c = '0;
    for (int i = 0; i < N_PLAYERS; i++)
      c = c + {{PW{1'b0}}, a[i]};
    return c;
  endfunction

  function automatic logic [PW-1:0] next_alive(
    input logic [N_PLAYERS-1:0] a,
    input logic [PW-1:0]        cur
  );
    logic [PW-1:0] r;
    logic          found;
    int            idx;
    r     = cur;
    found = 1'b0;
    for (int k = 1; k < N_PLAYERS; k++) begin
      idx = (int'(cur) + k) % N_PLAYERS;
      if (!found && a[idx]) begin
        r     = PW'(idx);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [PW-1:0] first_alive(
    input logic [N_PLAYERS-1:0] a
  );
    logic [PW-1:0] r;
    r = '0;
    for (int i = N_PLAYERS - 1; i >= 0; i--)
      if (a[i]) r = PW'(i);
    return r;
  endfunction

  always_comb begin
    alive = '0;
    for (int i = 0; i < N_PLAYERS; i++)
      alive[i] = hp[i*HP_W +: HP_W] != '0;
  end

  assign alive_cnt  = count_alive(alive);
  assign aim_expire = frame_tick &&
                      (aim_cnt == CW'(AIM_TIMEOUT - 1));
  assign advance    = (state == RESOLVE) && (alive_cnt > 1);
  assign restart    = start && (state == IDLE || state == OVER);
  assign hit_ok     = (state == FLIGHT) && hit_valid &&
                      (int'(hit_player) < N_PLAYERS);
  assign hit_cur    = hp[int'(hit_player)*HP_W +: HP_W];

  wind_lfsr #(.SEED(LFSR_SEED)) u_wind (
    .clk  (clk60MHz),
    .rst  (rst),
    .step (advance),
    .q    (lfsr_q),
    .nxt  (lfsr_nxt)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:       if (start)      state_n = WAIT_READY;
      WAIT_READY: if (&ready)     state_n = AIM;
      AIM: begin
        // a throw on the final tick still counts
        if (throw_req)       state_n = FLIGHT;
        else if (aim_expire) state_n = RESOLVE;
      end
      FLIGHT:     if (throw_done) state_n = RESOLVE;
      RESOLVE:    state_n = (alive_cnt > 1) ? AIM : OVER;
      OVER:       if (start)      state_n = WAIT_READY;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk60MHz) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      active_player <= '0;
      turn          <= '0;
      wind          <= '0;
      throw_en      <= 1'b0;
      hp            <= HP_FULL;
      game_over     <= 1'b0;
      winner        <= NO_WIN;
      aim_cnt       <= '0;
    end else begin
      throw_en  <= (state_n == AIM);
      game_over <= (state_n == OVER);
      if (state != AIM)   aim_cnt <= '0;
      else if (frame_tick) aim_cnt <= aim_cnt + CW'(1);
      if (restart) begin
        hp            <= HP_FULL;
        turn          <= '0;
        active_player <= '0;
        winner        <= NO_WIN;
      end
      if (hit_ok)
        hp[int'(hit_player)*HP_W +: HP_W] <=
          (hit_cur > hit_damage) ? hit_cur - hit_damage : '0;
      if (advance) begin
        active_player <= next_alive(alive, active_player);
        turn          <= turn + TURN_W'(1);
        wind          <= lfsr_nxt[WIND_W-1:0];
      end else if (state == RESOLVE) begin
        winner <= (alive_cnt == '0) ? NO_WIN
                                    : {1'b0, first_alive(alive)};
      end
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed scoreboard bench for game_sequencer, 2- and 4-player instances.
// Both instances share control inputs; each phase checks one of them.
module tb_game_sequencer;
  import game_pkg::*;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic frame_tick = 1'b0;
  logic throw_req = 1'b0;
  logic throw_done = 1'b0;
  logic hit_valid = 1'b0;
  logic [1:0] ready2 = '0;
  logic [3:0] ready4 = '0;
  logic [0:0] hitp2 = '0;
  logic [1:0] hitp4 = '0;
  logic [6:0] dmg = '0;

  game_state_t st2, st4;
  logic [0:0]  ap2;
  logic [1:0]  ap4;
  logic [2:0]  turn2, turn4, wind2, wind4;
  logic        te2, te4, go2, go4;
  logic [13:0] hp2;
  logic [27:0] hp4;
  logic [1:0]  win2;
  logic [2:0]  win4;

  always #5 clk = ~clk;

  game_sequencer #(.N_PLAYERS(2)) dut2 (
    .clk60MHz(clk), .rst(rst), .start(start), .ready(ready2),
    .frame_tick(frame_tick), .throw_req(throw_req),
    .throw_done(throw_done), .hit_valid(hit_valid),
    .hit_player(hitp2), .hit_damage(dmg), .state(st2),
    .active_player(ap2), .turn(turn2), .wind(wind2),
    .throw_en(te2), .hp(hp2), .game_over(go2), .winner(win2)
  );

  game_sequencer #(.N_PLAYERS(4)) dut4 (
    .clk60MHz(clk), .rst(rst), .start(start), .ready(ready4),
    .frame_tick(frame_tick), .throw_req(throw_req),
    .throw_done(throw_done), .hit_valid(hit_valid),
    .hit_player(hitp4), .hit_damage(dmg), .state(st4),
    .active_player(ap4), .turn(turn4), .wind(wind4),
    .throw_en(te4), .hp(hp4), .game_over(go4), .winner(win4)
  );

  // Independent reference for the wind sequence.
  logic [7:0] lfsr_m = 8'hA5;
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    logic fb;
    fb = s[7] ^ s[5] ^ s[4] ^ s[3];
    return {s[6:0], fb};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic ck(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed=%0h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h",
               e.tag, obs, e.val);
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic thr();
    throw_req = 1'b1; tick(); throw_req = 1'b0;
  endtask

  task automatic done();
    throw_done = 1'b1; tick(); throw_done = 1'b0;
  endtask

  task automatic hit(input int p, input int d);
    hit_valid = 1'b1;
    hitp2 = 1'(p);
    hitp4 = 2'(p);
    dmg   = 7'(d);
    tick();
    hit_valid = 1'b0;
  endtask

  task automatic next_wind(output logic [31:0] w);
    lfsr_m = lfsr_step(lfsr_m);
    w = 32'(lfsr_m[2:0]);
  endtask

  logic [31:0] w;

  initial begin
    tick(); tick();
    // reset state
    ex("rst_state", 32'(IDLE));      ck(32'(st2));
    ex("rst_ap", 0);                 ck(32'(ap2));
    ex("rst_turn", 0);               ck(32'(turn2));
    ex("rst_wind", 0);               ck(32'(wind2));
    ex("rst_te", 0);                 ck(32'(te2));
    ex("rst_hp", 32'({7'd100, 7'd100})); ck(32'(hp2));
    ex("rst_go", 0);                 ck(32'(go2));
    ex("rst_win", 32'h3);            ck(32'(win2));
    rst = 1'b0;

    // basic turn: throw, hit p1 for 30, end of flight
    pulse_start();
    ex("t1_wait", 32'(WAIT_READY));  ck(32'(st2));
    ready2 = 2'b11;
    tick();
    ex("t1_aim", 32'(AIM));          ck(32'(st2));
    ex("t1_te1", 1);                 ck(32'(te2));
    thr();
    ex("t1_flight", 32'(FLIGHT));    ck(32'(st2));
    ex("t1_te0", 0);                 ck(32'(te2));
    hit(1, 30);
    ex("t1_hp", 32'({7'd70, 7'd100})); ck(32'(hp2));
    done();
    ex("t1_resolve", 32'(RESOLVE));  ck(32'(st2));
    tick();
    next_wind(w);
    ex("t1_aim2", 32'(AIM));         ck(32'(st2));
    ex("t1_ap", 1);                  ck(32'(ap2));
    ex("t1_turn", 1);                ck(32'(turn2));
    ex("t1_wind", w);                ck(32'(wind2));

    // aim timeout forfeits the turn
    frame_tick = 1'b1;
    repeat (599) tick();
    ex("t3_still_aim", 32'(AIM));    ck(32'(st2));
    tick();
    frame_tick = 1'b0;
    ex("t3_resolve", 32'(RESOLVE));  ck(32'(st2));
    tick();
    next_wind(w);
    ex("t3_ap", 0);                  ck(32'(ap2));
    ex("t3_turn", 2);                ck(32'(turn2));
    ex("t3_wind", w);                ck(32'(wind2));
    ex("t3_hp", 32'({7'd70, 7'd100})); ck(32'(hp2));

    // throw on the final tick wins over the timeout
    frame_tick = 1'b1;
    repeat (599) tick();
    throw_req = 1'b1;
    tick();
    throw_req = 1'b0;
    frame_tick = 1'b0;
    ex("t3_throw_wins", 32'(FLIGHT)); ck(32'(st2));
    done();
    tick();
    next_wind(w);
    ex("t3b_ap", 1);                 ck(32'(ap2));
    ex("t3b_turn", 3);               ck(32'(turn2));
    ex("t3b_wind", w);               ck(32'(wind2));

    // overkill saturates to 0, single survivor wins
    thr();
    hit(0, 120);
    ex("t4_hp_sat", 32'({7'd70, 7'd0})); ck(32'(hp2));
    done();
    tick();
    ex("t4_over", 32'(OVER));        ck(32'(st2));
    ex("t4_go", 1);                  ck(32'(go2));
    ex("t4_win", 1);                 ck(32'(win2));
    ex("t4_te", 0);                  ck(32'(te2));
    hit(1, 10);
    ex("t4_hp_frozen", 32'({7'd70, 7'd0})); ck(32'(hp2));

    // restart, ignored hit in AIM, then double knockout -> draw
    pulse_start();
    ex("t5_wait", 32'(WAIT_READY));  ck(32'(st2));
    ex("t5_reload", 32'({7'd100, 7'd100})); ck(32'(hp2));
    ex("t5_turn0", 0);               ck(32'(turn2));
    tick();
    hit(0, 50);
    ex("t6_aim_hit", 32'({7'd100, 7'd100})); ck(32'(hp2));
    thr();
    hit(0, 100);
    hit_valid = 1'b1; hitp2 = 1'b1; dmg = 7'd100;
    throw_done = 1'b1;
    tick();
    hit_valid = 1'b0; throw_done = 1'b0;
    ex("t5_hp0", 0);                 ck(32'(hp2));
    ex("t5_resolve", 32'(RESOLVE));  ck(32'(st2));
    tick();
    ex("t5_over", 32'(OVER));        ck(32'(st2));
    ex("t5_draw", 32'h3);            ck(32'(win2));

    // reset in flight abandons the game
    pulse_start();
    tick();
    thr();
    hit(0, 40);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    lfsr_m = 8'hA5;
    ex("t6_idle", 32'(IDLE));        ck(32'(st2));
    ex("t6_te", 0);                  ck(32'(te2));
    ex("t6_hp", 32'({7'd100, 7'd100})); ck(32'(hp2));

    // 4 players: dead player 2 is skipped, rotation wraps
    ready2 = 2'b00;
    pulse_start();
    ready4 = 4'hF;
    tick();
    ex("t2_aim", 32'(AIM));          ck(32'(st4));
    ex("t2_ap0", 0);                 ck(32'(ap4));
    thr();
    hit(2, 100);
    done();
    tick();
    next_wind(w);
    ex("t2_ap1", 1);                 ck(32'(ap4));
    ex("t2_hp", 32'({7'd100, 7'd0, 7'd100, 7'd100})); ck(32'(hp4));
    ex("t2_wind1", w);               ck(32'(wind4));
    thr();
    done();
    tick();
    next_wind(w);
    ex("t2_skip", 3);                ck(32'(ap4));
    ex("t2_turn2", 2);               ck(32'(turn4));
    ex("t2_wind2", w);               ck(32'(wind4));
    thr();
    done();
    tick();
    ex("t2_wrap", 0);                ck(32'(ap4));
    ex("t2_turn3", 3);               ck(32'(turn4));
    ex("t2_state", 32'(AIM));        ck(32'(st4));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
